// File: rtl/controle_pkg.sv
// Shared types and encodings for the multicycle control unit.
package controle_pkg;

    // FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        BUSCA   = 3'd0,
        DECOD   = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        ESCRITA = 3'd4,
        HALT    = 3'd5
    } estado_t;

    // Instruction classes produced by the opcode decoder
    typedef enum logic [2:0] {
        CL_R      = 3'd0,
        CL_I      = 3'd1,
        CL_JUMP   = 3'd2,
        CL_BEQ    = 3'd3,
        CL_LW     = 3'd4,
        CL_SW     = 3'd5,
        CL_HALT   = 3'd6,
        CL_ILEGAL = 3'd7
    } classe_t;

    // Opcodes with dedicated behaviour (low nibble of a legal opcode)
    localparam logic [3:0] OP_JUMP = 4'd11;
    localparam logic [3:0] OP_BEQ  = 4'd12;
    localparam logic [3:0] OP_LW   = 4'd13;
    localparam logic [3:0] OP_SW   = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    // ALU B operand select
    localparam logic [1:0] B_REG  = 2'b00;
    localparam logic [1:0] B_UM   = 2'b01;
    localparam logic [1:0] B_IMED = 2'b10;
    localparam logic [1:0] B_DESL = 2'b11;

    // PC source select
    localparam logic [1:0] CP_ULA   = 2'b00;
    localparam logic [1:0] CP_SAIDA = 2'b01;
    localparam logic [1:0] CP_JUMP  = 2'b10;

endpackage

// File: rtl/controle_decod.sv
// Combinational opcode classifier: maps an opcode onto its instruction class.
module controle_decod
    import controle_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op_i,
    output classe_t         classe_o
);

    logic legal;

    // Anything at or above 16 is outside the instruction set
    assign legal = ({1'b0, op_i} < (OP_W+1)'(16));

    // Classify legal opcodes by their low nibble
    always_comb begin
        classe_o = CL_ILEGAL;
        if (legal) begin
            case (op_i[3:0])
                4'd0, 4'd1, 4'd3, 4'd4, 4'd5:             classe_o = CL_R;
                4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:      classe_o = CL_I;
                OP_JUMP:                                  classe_o = CL_JUMP;
                OP_BEQ:                                   classe_o = CL_BEQ;
                OP_LW:                                    classe_o = CL_LW;
                OP_SW:                                    classe_o = CL_SW;
                OP_HALT:                                  classe_o = CL_HALT;
                default:                                  classe_o = CL_ILEGAL;
            endcase
        end
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: steps each instruction through fetch, decode,
// execute, memory and writeback, driving datapath muxes and write enables.
//
// state   | meaning
// --------+-----------------------------------------------------------
// BUSCA   | fetch: read memory at PC, PC+1 and IR load on mem_pronto
// DECOD   | latch opcode, precompute branch target in ALUOut
// EXEC    | ALU operation / jump / branch / address computation
// MEM     | load or store, held until mem_pronto
// ESCRITA | register bank writeback (ALUOut or MDR)
// HALT    | stopped (halt opcode or illegal opcode), left only by rst
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int ULA_W   = 4,
    parameter int ULA_ADD = 0,
    parameter int ULA_SUB = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             mem_pronto,
    output logic             EscCondCP,
    output logic             EscCP,
    output logic [ULA_W-1:0] ULA_OP,
    output logic             ULA_A,
    output logic [1:0]       ULA_B,
    output logic             EscIR,
    output logic [1:0]       FonteCP,
    output logic             EscReg,
    output logic             LerMem,
    output logic             EscMem,
    output logic             IouD,
    output logic             MemParaReg,
    output logic             parado,
    output logic             erro,
    output logic [CNT_W-1:0] instr_cont
);

    estado_t          estado_q, estado_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             parado_q, erro_q;
    logic [CNT_W-1:0] cont_q;
    classe_t          classe_in, classe_reg;
    logic             retira;

    // The zero flag is combined with EscCondCP in the datapath, not here
    logic unused_zero;
    assign unused_zero = zero;

    // Live opcode is classified only in DECOD; later states use the latched copy
    controle_decod #(.OP_W(OP_W)) u_decod_in (
        .op_i     (opcode),
        .classe_o (classe_in)
    );

    controle_decod #(.OP_W(OP_W)) u_decod_reg (
        .op_i     (op_q),
        .classe_o (classe_reg)
    );

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) estado_q <= BUSCA;
        else     estado_q <= estado_d;
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            BUSCA: begin
                if (mem_pronto) estado_d = DECOD;
            end
            DECOD: begin
                if (classe_in == CL_HALT || classe_in == CL_ILEGAL) estado_d = HALT;
                else                                                 estado_d = EXEC;
            end
            EXEC: begin
                case (classe_reg)
                    CL_R, CL_I:       estado_d = ESCRITA;
                    CL_JUMP, CL_BEQ:  estado_d = BUSCA;
                    CL_LW, CL_SW:     estado_d = MEM;
                    default:          estado_d = HALT;
                endcase
            end
            MEM: begin
                if (mem_pronto) estado_d = (classe_reg == CL_LW) ? ESCRITA : BUSCA;
            end
            ESCRITA: estado_d = BUSCA;
            HALT:    estado_d = HALT;
            default: estado_d = BUSCA;
        endcase
    end

    // An instruction retires when it hands control back to fetch
    assign retira = (estado_d == BUSCA) &&
                    (estado_q == EXEC || estado_q == MEM || estado_q == ESCRITA);

    assign op_d = (estado_q == DECOD) ? opcode : op_q;

    // Latched opcode, halt/error flags and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            parado_q <= 1'b0;
            erro_q   <= 1'b0;
            cont_q   <= '0;
        end else begin
            op_q     <= op_d;
            parado_q <= (estado_d == HALT);
            erro_q   <= erro_q | ((estado_q == DECOD) && (classe_in == CL_ILEGAL));
            if (retira) cont_q <= cont_q + 1'b1;
        end
    end

    // Control outputs; everything is held low while rst is asserted
    always_comb begin
        EscCondCP  = 1'b0;
        EscCP      = 1'b0;
        ULA_OP     = '0;
        ULA_A      = 1'b0;
        ULA_B      = B_REG;
        EscIR      = 1'b0;
        FonteCP    = CP_ULA;
        EscReg     = 1'b0;
        LerMem     = 1'b0;
        EscMem     = 1'b0;
        IouD       = 1'b0;
        MemParaReg = 1'b0;
        if (!rst) begin
            case (estado_q)
                BUSCA: begin
                    LerMem = 1'b1;
                    ULA_B  = B_UM;
                    ULA_OP = ULA_W'(ULA_ADD);
                    EscIR  = mem_pronto;
                    EscCP  = mem_pronto;
                end
                DECOD: begin
                    ULA_B  = B_DESL;
                    ULA_OP = ULA_W'(ULA_ADD);
                end
                EXEC: begin
                    case (classe_reg)
                        CL_R: begin
                            ULA_A  = 1'b1;
                            ULA_B  = B_REG;
                            ULA_OP = ULA_W'(op_q);
                        end
                        CL_I: begin
                            ULA_A  = 1'b1;
                            ULA_B  = B_IMED;
                            ULA_OP = ULA_W'(op_q);
                        end
                        CL_JUMP: begin
                            EscCP   = 1'b1;
                            FonteCP = CP_JUMP;
                        end
                        CL_BEQ: begin
                            EscCondCP = 1'b1;
                            FonteCP   = CP_SAIDA;
                            ULA_A     = 1'b1;
                            ULA_B     = B_REG;
                            ULA_OP    = ULA_W'(ULA_SUB);
                        end
                        CL_LW, CL_SW: begin
                            ULA_A  = 1'b1;
                            ULA_B  = B_IMED;
                            ULA_OP = ULA_W'(ULA_ADD);
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    IouD   = 1'b1;
                    LerMem = (classe_reg == CL_LW);
                    EscMem = (classe_reg == CL_SW);
                end
                ESCRITA: begin
                    EscReg     = 1'b1;
                    MemParaReg = (classe_reg == CL_LW);
                end
                default: ;
            endcase
        end
    end

    assign parado     = parado_q;
    assign erro       = erro_q;
    assign instr_cont = cont_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: a per-instruction transaction
// model predicts every cycle's outputs, a negedge process compares them.
module tb_controle_multiciclo;

    localparam int OP_W  = 5;
    localparam int ULA_W = 5;
    localparam int CNT_W = 2;

    localparam int K_R = 0, K_I = 1, K_J = 2, K_BEQ = 3, K_LW = 4, K_SW = 5, K_HALT = 6, K_ILL = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [OP_W-1:0]  opcode = '0;
    logic             zero = 1'b0;
    logic             mem_pronto = 1'b0;
    logic             EscCondCP, EscCP, ULA_A, EscIR, EscReg, LerMem, EscMem, IouD, MemParaReg;
    logic [ULA_W-1:0] ULA_OP;
    logic [1:0]       ULA_B, FonteCP;
    logic             parado, erro;
    logic [CNT_W-1:0] instr_cont;

    typedef struct packed {
        logic             esc_cond_cp;
        logic             esc_cp;
        logic [ULA_W-1:0] ula_op;
        logic             ula_a;
        logic [1:0]       ula_b;
        logic             esc_ir;
        logic [1:0]       fonte_cp;
        logic             esc_reg;
        logic             ler_mem;
        logic             esc_mem;
        logic             iou_d;
        logic             mem_para_reg;
        logic             parado;
        logic             erro;
        logic [CNT_W-1:0] cont;
    } vec_t;

    vec_t  exp_v = '0;
    vec_t  act_v;
    bit    chk_en = 1'b0;
    string tag = "init";
    int    n_vec = 0;
    int    n_err = 0;

    // Behavioural model status
    int    m_cnt = 0;
    bit    m_parado = 1'b0;
    bit    m_erro = 1'b0;

    // Per-instruction abort control
    int    k;
    int    abort_at;
    bit    aborted;

    controle_multiciclo #(
        .OP_W(OP_W), .ULA_W(ULA_W), .ULA_ADD(0), .ULA_SUB(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_pronto(mem_pronto),
        .EscCondCP(EscCondCP), .EscCP(EscCP), .ULA_OP(ULA_OP), .ULA_A(ULA_A), .ULA_B(ULA_B),
        .EscIR(EscIR), .FonteCP(FonteCP), .EscReg(EscReg), .LerMem(LerMem), .EscMem(EscMem),
        .IouD(IouD), .MemParaReg(MemParaReg), .parado(parado), .erro(erro), .instr_cont(instr_cont)
    );

    always #5 clk = ~clk;

    assign act_v = {EscCondCP, EscCP, ULA_OP, ULA_A, ULA_B, EscIR, FonteCP, EscReg,
                    LerMem, EscMem, IouD, MemParaReg, parado, erro, instr_cont};

    // Compare DUT against model every cycle, away from the rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL %s t=%0t got=%b want=%b", tag, $time, act_v, exp_v);
            end
        end
    end

    function automatic int classe(input int op);
        if (op >= 16) return K_ILL;
        if (op == 15) return K_HALT;
        if (op == 11) return K_J;
        if (op == 12) return K_BEQ;
        if (op == 13) return K_LW;
        if (op == 14) return K_SW;
        if (op == 0 || op == 1 || op == 3 || op == 4 || op == 5) return K_R;
        return K_I;
    endfunction

    function automatic vec_t base();
        vec_t v;
        v = '0;
        v.parado = m_parado;
        v.erro   = m_erro;
        v.cont   = CNT_W'(m_cnt);
        return v;
    endfunction

    task automatic model_reset();
        m_cnt    = 0;
        m_parado = 1'b0;
        m_erro   = 1'b0;
    endtask

    task automatic check_lit(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // One clock cycle of an instruction; at step abort_at rst is pulsed instead
    task automatic step(input vec_t e, input logic mp, input bit ret,
                        input logic [OP_W-1:0] op, input string nm);
        if (!aborted) begin
            opcode     = op;
            zero       = 1'($urandom);
            mem_pronto = mp;
            if (k == abort_at) begin
                rst   = 1'b1;
                exp_v = base();
                tag   = {nm, "_abort"};
                @(posedge clk); #1;
                rst = 1'b0;
                model_reset();
                aborted = 1'b1;
            end else begin
                exp_v = e;
                tag   = nm;
                @(posedge clk); #1;
                if (ret) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
        end
        k++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            opcode     = OP_W'($urandom);
            mem_pronto = 1'($urandom);
            exp_v      = base();
            tag        = "reset";
            @(posedge clk); #1;
            model_reset();
        end
        rst = 1'b0;
    endtask

    task automatic hold_halt(input int n);
        vec_t e;
        k = 0; abort_at = -1; aborted = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = base();
            step(e, 1'($urandom), 1'b0, OP_W'($urandom), "halt");
        end
    endtask

    // Whole instruction: fw fetch wait cycles, mw memory wait cycles
    task automatic run_instr(input int op, input int fw, input int mw, input int ab);
        vec_t e;
        int   c;
        k = 0; abort_at = ab; aborted = 1'b0;
        c = classe(op);
        for (int w = 0; w <= fw; w++) begin
            e = base();
            e.ler_mem = 1'b1;
            e.ula_b   = 2'b01;
            e.esc_ir  = (w == fw);
            e.esc_cp  = (w == fw);
            step(e, (w == fw), 1'b0, OP_W'($urandom), "busca");
        end
        if (aborted) return;
        e = base();
        e.ula_b = 2'b11;
        step(e, 1'($urandom), 1'b0, OP_W'(op), "decod");
        if (aborted) return;
        if (c == K_HALT || c == K_ILL) begin
            m_parado = 1'b1;
            if (c == K_ILL) m_erro = 1'b1;
            return;
        end
        e = base();
        case (c)
            K_R:   begin e.ula_a = 1'b1; e.ula_b = 2'b00; e.ula_op = ULA_W'(op); end
            K_I:   begin e.ula_a = 1'b1; e.ula_b = 2'b10; e.ula_op = ULA_W'(op); end
            K_J:   begin e.esc_cp = 1'b1; e.fonte_cp = 2'b10; end
            K_BEQ: begin e.esc_cond_cp = 1'b1; e.fonte_cp = 2'b01; e.ula_a = 1'b1; e.ula_op = ULA_W'(1); end
            default: begin e.ula_a = 1'b1; e.ula_b = 2'b10; end
        endcase
        step(e, 1'($urandom), (c == K_J || c == K_BEQ), OP_W'($urandom), "exec");
        if (aborted || c == K_J || c == K_BEQ) return;
        if (c == K_LW || c == K_SW) begin
            for (int w = 0; w <= mw; w++) begin
                e = base();
                e.iou_d   = 1'b1;
                e.ler_mem = (c == K_LW);
                e.esc_mem = (c == K_SW);
                step(e, (w == mw), (c == K_SW && w == mw), OP_W'($urandom), "mem");
            end
        end
        if (aborted || c == K_SW) return;
        e = base();
        e.esc_reg      = 1'b1;
        e.mem_para_reg = (c == K_LW);
        step(e, 1'($urandom), 1'b1, OP_W'($urandom), "escrita");
    endtask

    initial begin
        int r, op, fw, mw;
        // First edge brings the DUT out of X; check from the second reset cycle
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        chk_en = 1'b1;
        do_reset(1);
        check_lit("reset_cnt", int'(instr_cont), 0);
        check_lit("reset_parado", int'(parado), 0);

        run_instr(4, 0, 0, -1);
        check_lit("cnt_after_r", int'(instr_cont), 1);
        run_instr(13, 0, 3, -1);
        run_instr(12, 0, 0, -1);
        run_instr(12, 1, 0, -1);
        check_lit("cnt_wrap", int'(instr_cont), 0);
        run_instr(11, 0, 0, -1);
        run_instr(14, 0, 0, -1);
        run_instr(7, 2, 0, -1);
        check_lit("cnt_after_i", int'(instr_cont), 3);

        // Reset during a store's memory wait
        do_reset(1);
        run_instr(14, 0, 2, 3);
        check_lit("abort_cnt", int'(instr_cont), 0);
        run_instr(0, 0, 0, -1);
        check_lit("cnt_after_abort", int'(instr_cont), 1);

        // Halt opcode
        run_instr(15, 0, 0, -1);
        hold_halt(20);
        check_lit("halt_parado", int'(parado), 1);
        check_lit("halt_erro", int'(erro), 0);
        check_lit("halt_cnt", int'(instr_cont), 1);
        do_reset(1);
        check_lit("halt_rst_parado", int'(parado), 0);

        // Illegal opcode
        run_instr(20, 0, 0, -1);
        hold_halt(3);
        check_lit("ilegal_erro", int'(erro), 1);
        check_lit("ilegal_parado", int'(parado), 1);
        do_reset(1);
        check_lit("ilegal_rst_erro", int'(erro), 0);

        // Randomised instruction stream
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            if (r < 5) begin
                op = ($urandom_range(0, 1) == 0) ? 15 : $urandom_range(16, 31);
                run_instr(op, fw, mw, -1);
                hold_halt($urandom_range(1, 5));
                do_reset($urandom_range(1, 2));
            end else if (r < 12) begin
                run_instr($urandom_range(0, 14), fw, mw, $urandom_range(0, 8));
            end else begin
                run_instr($urandom_range(0, 14), fw, mw, -1);
            end
        end

        chk_en = 1'b0;
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Parametrised multicycle control unit for the processor datapath, the successor to the single-state opcode-to-control decoder. A registered FSM steps each instruction through fetch, decode, execute, memory and writeback states. It adds load/store with a memory-ready handshake, a halt/illegal-opcode trap and a retired-instruction counter. Drives the datapath muxes and write enables (PC, IR, register bank, memory) and the ALU operation.

Parameters:
OP_W, 4, opcode width; legal opcodes are 0..15, any value >=16 is illegal
ULA_W, 4, ULA_OP width, must be >= OP_W; opcode is zero-extended onto ULA_OP
ULA_ADD, 0, ULA_OP code for address/PC addition
ULA_SUB, 1, ULA_OP code for branch compare
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
opcode  in  OP_W  opcode field from IR, valid from DECOD onward
zero  in  1  ALU zero flag (datapath combines EscCondCP & zero)
mem_pronto  in  1  memory ready; completes the current read/write this cycle
EscCondCP  out  1  conditional PC write
EscCP  out  1  unconditional PC write
ULA_OP  out  ULA_W  ALU operation
ULA_A  out  1  ALU A: 0=PC, 1=reg A
ULA_B  out  2  ALU B: 00=reg B, 01=const 1, 10=immediate, 11=shifted immediate
EscIR  out  1  IR write
FonteCP  out  2  PC source: 00=ALU, 01=ALUOut (branch target), 10=jump target
EscReg  out  1  register bank write
LerMem  out  1  memory read
EscMem  out  1  memory write
IouD  out  1  memory address: 0=PC, 1=ALUOut
MemParaReg  out  1  writeback data: 0=ALUOut, 1=MDR
parado  out  1  halted
erro  out  1  sticky illegal-opcode flag
instr_cont  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst high at posedge): state=BUSCA, op_reg=0, parado=0, erro=0, instr_cont=0. All control outputs are forced to 0 while rst is high.
- Registers: state, op_reg (opcode latched in DECOD), parado, erro, instr_cont. Control outputs are combinational from state, op_reg and mem_pronto. All outputs not listed for a state are 0.
- BUSCA: LerMem=1, IouD=0, ULA_A=0, ULA_B=01, ULA_OP=ULA_ADD, FonteCP=00.
  - EscIR=EscCP=mem_pronto.
  - Stay in BUSCA while !mem_pronto; go to DECOD when mem_pronto=1.
- DECOD: op_reg<=opcode. ULA_A=0, ULA_B=11, ULA_OP=ULA_ADD (precomputes branch target).
  - opcode 15 -> HALT.
  - opcode >=16 -> HALT with erro<=1.
  - All other opcodes -> EXEC.
- EXEC, by class of op_reg:
  - R-type {0,1,3,4,5}: ULA_A=1, ULA_B=00, ULA_OP=op -> ESCRITA.
  - I-type {2,6,7,8,9,10}: ULA_A=1, ULA_B=10, ULA_OP=op -> ESCRITA.
  - Jump 11: EscCP=1, FonteCP=10 -> BUSCA (retire).
  - Branch 12: EscCondCP=1, FonteCP=01, ULA_A=1, ULA_B=00, ULA_OP=ULA_SUB -> BUSCA (retire). The PC is written only if zero=1; the datapath performs that gating.
  - Load 13 / store 14: ULA_A=1, ULA_B=10, ULA_OP=ULA_ADD -> MEM.
- MEM: IouD=1. LerMem=1 (load) or EscMem=1 (store), held until mem_pronto.
  - Load + mem_pronto -> ESCRITA.
  - Store + mem_pronto -> BUSCA (retire).
- ESCRITA: EscReg=1 for exactly one cycle; MemParaReg=1 iff op_reg=13 -> BUSCA (retire).
- HALT: parado=1, all enables 0. Stays in HALT until rst.
- Retire: instr_cont increments by 1 on each transition into BUSCA from EXEC/MEM/ESCRITA. Wraps modulo 2^CNT_W. HALT does not count.
- Latency with mem_pronto always 1:
  - jump/branch: 3 cycles
  - R/I-type and store: 4 cycles
  - load: 5 cycles
  - each mem_pronto=0 cycle in BUSCA or MEM adds 1 cycle.
- A change on opcode after DECOD has no effect, because op_reg is used.
- rst mid-instruction (including during a MEM wait) aborts the instruction: BUSCA next and no retire. A write enable active in that cycle is suppressed.

Decomposition:
- controle_pkg:
  - state enum (BUSCA, DECOD, EXEC, MEM, ESCRITA, HALT), 3-bit
  - opcode constants OP_JUMP=11, OP_BEQ=12, OP_LW=13, OP_SW=14, OP_HALT=15
  - ULA_B encodings (B_REG, B_UM, B_IMED, B_DESL)
  - FonteCP encodings (CP_ULA, CP_SAIDA, CP_JUMP)
- Sub-module controle_decod: combinational op_reg -> class (R, I, JUMP, BEQ, LW, SW, HALT, ILEGAL).

Test Plan:
- R-type op=4, mem_pronto=1 -> states BUSCA, DECOD, EXEC, ESCRITA. ULA_OP=4, ULA_A=1, ULA_B=00 in EXEC. EscReg=1 exactly in cycle 4. instr_cont 0->1.
- Load op=13, mem_pronto held 0 for 3 MEM cycles -> LerMem=1 and IouD=1 for 4 cycles. ESCRITA has EscReg=1 and MemParaReg=1. Total 8 cycles.
- Branch op=12 -> EXEC shows EscCondCP=1, FonteCP=01, ULA_OP=ULA_SUB, EscCP=0. Then BUSCA. instr_cont+1 regardless of zero.
- Jump op=11 -> EscCP=1, FonteCP=10 in cycle 3. Store op=14 -> EscMem=1 then BUSCA, EscReg never 1.
- op=15 -> HALT, parado=1, all enables 0 for 20 cycles, count frozen. With OP_W=5, op=20 -> HALT and erro=1. rst -> parado=0, erro=0.
- rst asserted during MEM of a store -> EscMem=0 that cycle. BUSCA next, instr_cont unchanged. CNT_W=2 after 4 retires -> instr_cont=0.
